reg_if_adapter: RTL and testbench

REG_IF_ADAPTER -- requirements
Module: reg_if_adapter

---
 rtl/reg_if_pkg.sv | 17 +
 rtl/reg_if_decode.sv | 38 +++
 rtl/reg_if_adapter.sv | 128 ++++++++++++
 tb/tb_reg_if_adapter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_if_pkg.sv
// Shared types and constants for the register-interface adapter.
package reg_if_pkg;

  // Adapter transaction FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Error-cause vector: one bit per reason a request is rejected
  localparam int ERR_W        = 3;
  localparam int ERR_MISALIGN = 0;  // address not word aligned
  localparam int ERR_RANGE    = 1;  // word index beyond the last register
  localparam int ERR_BE       = 2;  // partial-word write

endpackage

// File: rtl/reg_if_decode.sv
// Combinational request decode: register index, one-hot select and error flag.
// The one-hot vector is already suppressed when the request is in error.
module reg_if_decode
  import reg_if_pkg::*;
#(
  parameter int AW   = 8,
  parameter int DW   = 32,
  parameter int NREG = 8
) (
  input  logic [AW-1:0]   addr,
  input  logic [DW/8-1:0] be,
  input  logic            write,
  output logic [NREG-1:0] onehot,
  output logic            error
);

  logic [AW-3:0]    idx;
  logic [ERR_W-1:0] cause;

  assign idx = addr[AW-1:2];

  // Collect every reason the request cannot be serviced
  always_comb begin
    cause               = '0;
    cause[ERR_MISALIGN] = |addr[1:0];
    cause[ERR_RANGE]    = ({1'b0, idx} >= (AW-1)'(NREG));
    cause[ERR_BE]       = write && !(&be);
  end

  assign error = |cause;

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_hot
      assign onehot[gi] = (idx == (AW-2)'(gi)) && !error;
    end
  endgenerate

endmodule

// File: rtl/reg_if_adapter.sv
// Valid/ready bus request to register-slice strobe adapter.
// One transaction at a time: accept (IDLE) -> strobe (EXEC) -> respond (RESP).
module reg_if_adapter
  import reg_if_pkg::*;
#(
  parameter int AW   = 8,
  parameter int DW   = 32,
  parameter int NREG = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_write_i,
  input  logic [AW-1:0]      req_addr_i,
  input  logic [DW-1:0]      req_wdata_i,
  input  logic [DW/8-1:0]    req_be_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [DW-1:0]      rsp_rdata_o,
  output logic               rsp_error_o,
  output logic [NREG-1:0]    reg_we_o,
  output logic [NREG-1:0]    reg_re_o,
  output logic [DW-1:0]      reg_wd_o,
  input  logic [NREG*DW-1:0] reg_rdata_i
);

  state_t            state_reg, state_next;
  logic              write_reg;
  logic [AW-1:0]     addr_reg;
  logic [DW-1:0]     wdata_reg;
  logic [DW/8-1:0]   be_reg;
  logic [DW-1:0]     rdata_reg;
  logic              error_reg;
  logic [NREG-1:0]   hot;
  logic              dec_error;
  logic [DW-1:0]     rdata_sel;
  logic              accept;

  // Decode works on the latched request so EXEC is independent of bus inputs
  reg_if_decode #(
    .AW   (AW),
    .DW   (DW),
    .NREG (NREG)
  ) u_decode (
    .addr   (addr_reg),
    .be     (be_reg),
    .write  (write_reg),
    .onehot (hot),
    .error  (dec_error)
  );

  assign accept = (state_reg == ST_IDLE) && req_valid_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  // Next-state logic: EXEC lasts exactly one cycle, RESP waits for the handshake
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (req_valid_i) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: if (rsp_ready_i) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; strobes exist only during EXEC so reset kills them at once
  always_comb begin
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    reg_we_o    = '0;
    reg_re_o    = '0;
    reg_wd_o    = '0;
    case (state_reg)
      ST_IDLE: req_ready_o = 1'b1;
      ST_EXEC: begin
        reg_we_o = write_reg ? hot : '0;
        reg_re_o = write_reg ? '0 : hot;
        reg_wd_o = wdata_reg;
      end
      ST_RESP: rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Holding registers capture the request on the accept cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      write_reg <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      be_reg    <= '0;
    end else if (accept) begin
      write_reg <= req_write_i;
      addr_reg  <= req_addr_i;
      wdata_reg <= req_wdata_i;
      be_reg    <= req_be_i;
    end
  end

  // Read mux driven by the one-hot select; all zeros when the request is in error
  always_comb begin
    rdata_sel = '0;
    for (int k = 0; k < NREG; k++) begin
      if (hot[k]) rdata_sel = rdata_sel | reg_rdata_i[k*DW +: DW];
    end
  end

  // Response captured in EXEC (pre-clear value of read-to-clear registers), held through RESP
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_reg <= '0;
      error_reg <= 1'b0;
    end else if (state_reg == ST_EXEC) begin
      rdata_reg <= write_reg ? '0 : rdata_sel;
      error_reg <= dec_error;
    end
  end

  assign rsp_rdata_o = rdata_reg;
  assign rsp_error_o = error_reg;

endmodule

// File: tb/tb_reg_if_adapter.sv
// Randomized self-checking bench for reg_if_adapter against a transaction-level model.
module tb_reg_if_adapter;

  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int NREG = 8;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic               req_valid_i = 1'b0;
  logic               req_ready_o;
  logic               req_write_i = 1'b0;
  logic [AW-1:0]      req_addr_i = '0;
  logic [DW-1:0]      req_wdata_i = '0;
  logic [DW/8-1:0]    req_be_i = '0;
  logic               rsp_valid_o;
  logic               rsp_ready_i = 1'b0;
  logic [DW-1:0]      rsp_rdata_o;
  logic               rsp_error_o;
  logic [NREG-1:0]    reg_we_o;
  logic [NREG-1:0]    reg_re_o;
  logic [DW-1:0]      reg_wd_o;
  logic [NREG*DW-1:0] reg_rdata_i;

  logic [DW-1:0] words [NREG];
  int tests = 0;
  int fails = 0;
  int txn_no = 0;
  int cyc = 0;
  int last_accept = 0;

  reg_if_adapter #(.AW(AW), .DW(DW), .NREG(NREG)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_write_i (req_write_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_be_i    (req_be_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_error_o (rsp_error_o),
    .reg_we_o    (reg_we_o),
    .reg_re_o    (reg_re_o),
    .reg_wd_o    (reg_wd_o),
    .reg_rdata_i (reg_rdata_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_rd
      assign reg_rdata_i[gi*DW +: DW] = words[gi];
    end
  endgenerate

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model: a request is rejected if misaligned, beyond the register file, or a partial write
  function automatic bit model_err(input bit w, input int addr, input int be);
    return (addr % 4 != 0) || (addr / 4 >= NREG) || (w && be != 15);
  endfunction

  task automatic shuffle_words();
    for (int k = 0; k < NREG; k++) words[k] = $urandom;
  endtask

  task automatic drive_garbage();
    req_valid_i = 1'($urandom_range(0, 1));
    req_write_i = 1'($urandom_range(0, 1));
    req_addr_i  = AW'($urandom);
    req_wdata_i = $urandom;
    req_be_i    = 4'($urandom);
  endtask

  // One full transaction; called #1 after a rising edge with the DUT expected in IDLE
  task automatic run_txn(input bit w, input int addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int stall, input bit shuffle);
    bit          err;
    int          idx;
    logic [31:0] exp_hot;
    logic [31:0] exp_rd;
    logic [31:0] a_bits;
    err     = model_err(w, addr, int'(be));
    idx     = addr / 4;
    exp_hot = err ? 32'd0 : (32'd1 << idx);
    a_bits  = addr;
    check_eq("ready_idle", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1;
    req_write_i = w;
    req_addr_i  = a_bits[AW-1:0];
    req_wdata_i = wdata;
    req_be_i    = be;
    @(posedge clk_i); #1;
    last_accept = cyc;
    // EXEC cycle: bus inputs change, only the latched request matters
    drive_garbage();
    if (shuffle) shuffle_words();
    exp_rd = 32'd0;
    if (!err && !w) exp_rd = words[idx];
    check_eq("we_exec", 32'(reg_we_o), w ? exp_hot : 32'd0);
    check_eq("re_exec", 32'(reg_re_o), w ? 32'd0 : exp_hot);
    check_eq("wd_exec", reg_wd_o, wdata);
    check_eq("ready_exec", 32'(req_ready_o), 32'd0);
    check_eq("rspv_exec", 32'(rsp_valid_o), 32'd0);
    @(posedge clk_i); #1;
    for (int c = 0; c <= stall; c++) begin
      if (shuffle) shuffle_words();
      check_eq("rspv_resp", 32'(rsp_valid_o), 32'd1);
      check_eq("rdata_resp", rsp_rdata_o, exp_rd);
      check_eq("error_resp", 32'(rsp_error_o), 32'(err));
      check_eq("ready_resp", 32'(req_ready_o), 32'd0);
      check_eq("strobe_resp", {16'd0, reg_we_o, reg_re_o}, 32'd0);
      check_eq("wd_resp", reg_wd_o, 32'd0);
      rsp_ready_i = (c == stall);
      drive_garbage();
      @(posedge clk_i); #1;
    end
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b0;
    check_eq("rspv_idle", 32'(rsp_valid_o), 32'd0);
    check_eq("strobe_idle", {16'd0, reg_we_o, reg_re_o}, 32'd0);
    txn_no++;
    $display("[TB] txn %0d %s addr=0x%02h be=0x%0h wdata=0x%08h stall=%0d exp_err=%0d exp_rdata=0x%08h",
             txn_no, w ? "WR" : "RD", addr, be, wdata, stall, err, exp_rd);
  endtask

  initial begin
    int prev;
    shuffle_words();
    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_rspv", 32'(rsp_valid_o), 32'd0);
    check_eq("rst_rdata", rsp_rdata_o, 32'd0);
    check_eq("rst_error", 32'(rsp_error_o), 32'd0);
    check_eq("rst_strobes", {16'd0, reg_we_o, reg_re_o}, 32'd0);
    check_eq("rst_wd", reg_wd_o, 32'd0);
    rst_ni = 1'b1;
    check_eq("ready_after_rst", 32'(req_ready_o), 32'd1);

    // Directed: write word 2, read word 1, the three error kinds, a 5-cycle stall
    run_txn(1'b1, 'h08, 32'hDEADBEEF, 4'hF, 0, 1'b0);
    words[1] = 32'h12345678;
    run_txn(1'b0, 'h04, 32'h0, 4'hF, 0, 1'b0);
    run_txn(1'b1, 'h22, 32'hA5A5A5A5, 4'hF, 0, 1'b0);
    run_txn(1'b1, 'h20, 32'h5A5A5A5A, 4'hF, 0, 1'b0);
    run_txn(1'b1, 'h00, 32'h01020304, 4'h3, 0, 1'b0);
    run_txn(1'b0, 'h1C, 32'h0, 4'h0, 5, 1'b0);

    // Back-to-back reads: one accept every 3 cycles
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b0, 4 * (i % NREG), 32'h0, 4'hF, 0, 1'b0);
      if (prev >= 0) check_eq("b2b_period", 32'(last_accept - prev), 32'd3);
      prev = last_accept;
    end

    // Reset during EXEC of a write
    check_eq("ready_pre_rst", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 8'h0C;
    req_wdata_i = 32'hCAFEF00D; req_be_i = 4'hF;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    check_eq("we_before_rst", 32'(reg_we_o), 32'h08);
    rst_ni = 1'b0;
    #1;
    check_eq("we_in_rst", 32'(reg_we_o), 32'd0);
    check_eq("wd_in_rst", reg_wd_o, 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    check_eq("ready_rel", 32'(req_ready_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check_eq("no_rsp_rel", 32'(rsp_valid_o), 32'd0);
      check_eq("no_strobe_rel", {16'd0, reg_we_o, reg_re_o}, 32'd0);
      @(posedge clk_i); #1;
    end
    $display("[TB] txn reset-during-exec dropped");

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      bit          w;
      int          addr;
      logic [3:0]  be;
      w    = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 3) != 0) ? 4 * $urandom_range(0, NREG - 1) : $urandom_range(0, 255);
      be   = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
      run_txn(w, addr, $urandom, be, $urandom_range(0, 3), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
